// File: rtl/nf10_wrr_input_arbiter_if.sv
// AXI4-Stream bundle; LANES > 1 carries several streams flattened side by side,
// lane p occupying slice p of every field.
interface nf10_wrr_input_arbiter_if #(
   parameter int DATA_WIDTH  = 64,
   parameter int TUSER_WIDTH = 128,
   parameter int LANES       = 1
);
   logic [LANES*DATA_WIDTH-1:0]   tdata;
   logic [LANES*DATA_WIDTH/8-1:0] tstrb;
   logic [LANES*TUSER_WIDTH-1:0]  tuser;
   logic [LANES-1:0]              tvalid;
   logic [LANES-1:0]              tlast;
   logic [LANES-1:0]              tready;

   modport master (output tdata, tstrb, tuser, tvalid, tlast, input tready);
   modport slave  (input tdata, tstrb, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/nf10_wrr_input_arbiter.sv
// Packet-granular weighted round-robin merge of C_NUM_PORTS AXI4-Stream inputs
// onto one output, registered through a two-entry skid buffer.
module nf10_wrr_input_arbiter #(
   parameter int C_M_AXIS_DATA_WIDTH  = 64,
   parameter int C_S_AXIS_DATA_WIDTH  = 64,
   parameter int C_M_AXIS_TUSER_WIDTH = 128,
   parameter int C_S_AXIS_TUSER_WIDTH = 128,
   parameter int C_NUM_PORTS          = 5,
   parameter int C_WEIGHT_WIDTH       = 4
) (
   input  logic                                   axi_aclk,
   input  logic                                   axi_resetn,
   nf10_wrr_input_arbiter_if.slave                s_axis,
   nf10_wrr_input_arbiter_if.master               m_axis,
   input  logic [C_NUM_PORTS*C_WEIGHT_WIDTH-1:0]  weights,
   output logic [$clog2(C_NUM_PORTS)-1:0]         cur_port,
   output logic                                   busy
);
   localparam int NP = C_NUM_PORTS;
   localparam int PW = $clog2(NP);
   localparam int WW = C_WEIGHT_WIDTH;
   localparam int DW = C_S_AXIS_DATA_WIDTH;
   localparam int SW = DW / 8;
   localparam int UW = C_S_AXIS_TUSER_WIDTH;
   localparam int BW = DW + SW + UW + 1;

   typedef enum logic {IDLE, PKT} state_t;

   state_t        state_reg;
   logic [PW-1:0] ptr_reg;
   logic [PW-1:0] grant_reg;
   logic [PW-1:0] cur_port_reg;
   logic [WW-1:0] credit_reg;
   logic          busy_reg;
   logic [NP-1:0] tready_reg;

   logic [BW-1:0] main_beat_reg;
   logic [BW-1:0] skid_beat_reg;
   logic          main_valid_reg;
   logic          skid_valid_reg;
   logic          main_valid_next;
   logic          skid_valid_next;
   logic          load_main_from_skid;
   logic          load_main_from_in;
   logic          load_skid;

   logic [BW-1:0] in_beat [NP];
   logic [WW-1:0] weight  [NP];
   logic [BW-1:0] sel_beat;
   logic          sel_last;
   logic          accept;
   logic          drain;
   logic [PW-1:0] grant_inc;

   logic          cand_found;
   logic [PW-1:0] cand;
   logic [PW:0]   scan_sum;

   // Beat layout inside the output stage: {last, user, strb, data}.
   genvar gi;
   generate
      for (gi = 0; gi < NP; gi++) begin : g_port
         assign in_beat[gi] = {s_axis.tlast[gi],
                               s_axis.tuser[gi*UW +: UW],
                               s_axis.tstrb[gi*SW +: SW],
                               s_axis.tdata[gi*DW +: DW]};
         assign weight[gi]        = weights[gi*WW +: WW];
         assign s_axis.tready[gi] = tready_reg[gi];
      end
   endgenerate

   assign sel_beat  = in_beat[grant_reg];
   assign sel_last  = sel_beat[BW-1];
   assign accept    = (state_reg == PKT) && s_axis.tvalid[grant_reg] && tready_reg[grant_reg];
   assign drain     = main_valid_reg && m_axis.tready[0];
   assign grant_inc = (grant_reg == PW'(NP - 1)) ? '0 : grant_reg + PW'(1);

   // Rotating scan: first valid port at or after ptr, wrapping modulo NP.
   always_comb begin
      cand_found = 1'b0;
      cand       = '0;
      scan_sum   = '0;
      for (int i = 0; i < NP; i++) begin
         scan_sum = {1'b0, ptr_reg} + (PW+1)'(i);
         if (scan_sum >= (PW+1)'(NP)) begin
            scan_sum = scan_sum - (PW+1)'(NP);
         end
         if (!cand_found && s_axis.tvalid[scan_sum[PW-1:0]]) begin
            cand_found = 1'b1;
            cand       = scan_sum[PW-1:0];
         end
      end
   end

   // Skid occupancy: main always fills first, skid only catches a beat that
   // arrives while main is stalled.
   always_comb begin
      main_valid_next     = main_valid_reg;
      skid_valid_next     = skid_valid_reg;
      load_main_from_skid = 1'b0;
      load_main_from_in   = 1'b0;
      load_skid           = 1'b0;
      if (!main_valid_reg || drain) begin
         if (skid_valid_reg) begin
            load_main_from_skid = 1'b1;
            main_valid_next     = 1'b1;
            skid_valid_next     = accept;
            load_skid           = accept;
         end else begin
            main_valid_next   = accept;
            load_main_from_in = accept;
         end
      end else if (accept) begin
         skid_valid_next = 1'b1;
         load_skid       = 1'b1;
      end
   end

   always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         state_reg      <= IDLE;
         ptr_reg        <= '0;
         credit_reg     <= '0;
         grant_reg      <= '0;
         cur_port_reg   <= '0;
         busy_reg       <= 1'b0;
         tready_reg     <= '0;
         main_valid_reg <= 1'b0;
         skid_valid_reg <= 1'b0;
      end else begin
         main_valid_reg <= main_valid_next;
         skid_valid_reg <= skid_valid_next;
         tready_reg     <= '0;
         case (state_reg)
            IDLE: begin
               if (cand_found) begin
                  grant_reg         <= cand;
                  cur_port_reg      <= cand;
                  state_reg         <= PKT;
                  busy_reg          <= 1'b1;
                  tready_reg[cand]  <= !skid_valid_next;
                  // A fresh turn loads credit; a continuing turn keeps it.
                  if (cand != ptr_reg || credit_reg == '0) begin
                     ptr_reg    <= cand;
                     credit_reg <= (weight[cand] == '0) ? WW'(1) : weight[cand];
                  end
               end
            end
            PKT: begin
               if (accept && sel_last) begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
                  if (credit_reg == WW'(1)) begin
                     ptr_reg    <= grant_inc;
                     credit_reg <= '0;
                  end else begin
                     credit_reg <= credit_reg - WW'(1);
                  end
               end else begin
                  tready_reg[grant_reg] <= !skid_valid_next;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // Payload registers need no reset; their valid bits qualify them.
   always_ff @(posedge axi_aclk) begin
      if (load_main_from_skid) begin
         main_beat_reg <= skid_beat_reg;
      end else if (load_main_from_in) begin
         main_beat_reg <= sel_beat;
      end
      if (load_skid) begin
         skid_beat_reg <= sel_beat;
      end
   end

   assign m_axis.tdata  = main_beat_reg[0 +: C_M_AXIS_DATA_WIDTH];
   assign m_axis.tstrb  = main_beat_reg[DW +: C_M_AXIS_DATA_WIDTH/8];
   assign m_axis.tuser  = main_beat_reg[DW+SW +: C_M_AXIS_TUSER_WIDTH];
   assign m_axis.tlast  = main_beat_reg[BW-1];
   assign m_axis.tvalid = main_valid_reg;
   assign cur_port      = cur_port_reg;
   assign busy          = busy_reg;
endmodule

// File: tb/tb_nf10_wrr_input_arbiter.sv
// Randomised bench for the WRR input arbiter: a packet-level WRR model predicts
// the exact output beat stream, which is compared beat by beat.
module tb_nf10_wrr_input_arbiter;
   localparam int NP = 5;
   localparam int DW = 64;
   localparam int SW = 8;
   localparam int UW = 128;
   localparam int WW = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst_n   = 1'b1;
   logic [NP*WW-1:0] weights = '0;
   logic [2:0]       cur_port;
   logic             busy;

   nf10_wrr_input_arbiter_if #(.DATA_WIDTH(DW), .TUSER_WIDTH(UW), .LANES(NP)) s_if ();
   nf10_wrr_input_arbiter_if #(.DATA_WIDTH(DW), .TUSER_WIDTH(UW), .LANES(1))  m_if ();

   nf10_wrr_input_arbiter #(
      .C_M_AXIS_DATA_WIDTH(DW), .C_S_AXIS_DATA_WIDTH(DW),
      .C_M_AXIS_TUSER_WIDTH(UW), .C_S_AXIS_TUSER_WIDTH(UW),
      .C_NUM_PORTS(NP), .C_WEIGHT_WIDTH(WW)
   ) dut (
      .axi_aclk(clk), .axi_resetn(rst_n), .s_axis(s_if.slave), .m_axis(m_if.master),
      .weights(weights), .cur_port(cur_port), .busy(busy)
   );

   typedef struct packed {
      logic [DW-1:0] data;
      logic [SW-1:0] strb;
      logic [UW-1:0] user;
      logic          last;
   } beat_t;

   beat_t src_q [NP][$];
   int    pkt_len [NP][$];
   int    src_pos [NP];
   bit    fire [NP];
   beat_t exp_q[$];
   int    exp_src_q[$];
   int    out_start_q[$];

   int checks = 0;
   int errors = 0;
   int rdy_mode = 0;
   bit bubbles = 0;
   int stall_port = -1;
   int stall_pos = 0;
   int stall_left = 0;
   int first_out = -1;
   int last_src = 0;
   int pkt_count = 0;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic int wt(input int p);
      return int'(weights[p*WW +: WW]);
   endfunction

   task automatic add_pkt(input int p, input int len);
      beat_t b;
      for (int i = 0; i < len; i++) begin
         b.data = {$urandom, $urandom};
         b.strb = 8'($urandom);
         b.user = {$urandom, $urandom, $urandom, $urandom};
         b.last = (i == len - 1);
         src_q[p].push_back(b);
      end
      pkt_len[p].push_back(len);
   endtask

   // Packet-level WRR: every port with packets left is contending at each decision.
   task automatic build_expected();
      int pend[NP];
      int pos[NP];
      int nxt[NP];
      int ptr = 0;
      int credit = 0;
      int left = 0;
      int c;
      int q;
      for (int p = 0; p < NP; p++) begin
         pend[p] = pkt_len[p].size();
         pos[p]  = 0;
         nxt[p]  = 0;
         left   += pend[p];
      end
      while (left > 0) begin
         c = -1;
         for (int i = 0; i < NP; i++) begin
            q = (ptr + i) % NP;
            if (c < 0 && pend[q] > 0) c = q;
         end
         if (c != ptr || credit == 0) begin
            ptr    = c;
            credit = (wt(c) == 0) ? 1 : wt(c);
         end
         for (int b = 0; b < pkt_len[c][nxt[c]]; b++) exp_q.push_back(src_q[c][pos[c] + b]);
         exp_src_q.push_back(c);
         pos[c] += pkt_len[c][nxt[c]];
         nxt[c]++;
         pend[c]--;
         left--;
         if (credit == 1) begin
            ptr    = (c + 1) % NP;
            credit = 0;
         end else begin
            credit--;
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_m_tvalid", 256'(m_if.tvalid), 256'(0));
      check("rst_s_tready", 256'(s_if.tready), 256'(0));
      check("rst_busy", 256'(busy), 256'(0));
      check("rst_cur_port", 256'(cur_port), 256'(0));
      s_if.tvalid = '0;
      s_if.tlast  = '0;
      for (int p = 0; p < NP; p++) begin
         src_q[p].delete();
         pkt_len[p].delete();
         src_pos[p] = 0;
         fire[p]    = 1'b0;
      end
      exp_q.delete();
      exp_src_q.delete();
      out_start_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic run(input int max_cyc, input int abort_cyc);
      beat_t b;
      beat_t got;
      beat_t held;
      beat_t e;
      bit    first;
      bit    v;
      bit    hold_prev = 1'b0;
      bit    in_pkt = 1'b0;
      int    hold_bad = 0;
      int    onehot_bad = 0;
      int    cur_src = 0;
      int    beats = 0;
      b = '0;
      held = '0;
      first_out = -1;
      for (int cyc = 0; cyc < max_cyc; cyc++) begin
         @(negedge clk);
         if (abort_cyc > 0 && cyc == abort_cyc) break;
         for (int p = 0; p < NP; p++) begin
            if (fire[p]) src_pos[p]++;
            v = 1'b0;
            if (src_pos[p] < src_q[p].size()) begin
               b     = src_q[p][src_pos[p]];
               first = (src_pos[p] == 0) || src_q[p][src_pos[p] - 1].last;
               v     = 1'b1;
               if (!first && bubbles && $urandom_range(0, 3) == 0) v = 1'b0;
               if (p == stall_port && src_pos[p] == stall_pos && stall_left > 0) begin
                  v = 1'b0;
                  stall_left--;
                  check("stall_busy", 256'(busy), 256'(1));
                  check("stall_cur_port", 256'(cur_port), 256'(p));
               end
               s_if.tdata[p*DW +: DW] = b.data;
               s_if.tstrb[p*SW +: SW] = b.strb;
               s_if.tuser[p*UW +: UW] = b.user;
            end
            s_if.tvalid[p] = v;
            s_if.tlast[p]  = v && b.last;
            fire[p]        = v && s_if.tready[p];
         end
         if ($countones(s_if.tready) > 1) onehot_bad++;
         case (rdy_mode)
            0:       m_if.tready = 1'b1;
            1:       m_if.tready = 1'($urandom_range(0, 9) < 7);
            2:       m_if.tready = 1'((cyc % 2 == 0) && !(cyc >= 10 && cyc < 15));
            default: m_if.tready = 1'b0;
         endcase
         got = {m_if.tdata, m_if.tstrb, m_if.tuser, m_if.tlast};
         if (hold_prev && (m_if.tvalid !== 1'b1 || got !== held)) hold_bad++;
         hold_prev = m_if.tvalid[0] && !m_if.tready[0];
         held      = got;
         if (first_out < 0 && m_if.tvalid[0]) first_out = cyc;
         if (m_if.tvalid[0] && m_if.tready[0]) begin
            if (exp_q.size() == 0) begin
               check("extra_beat", 256'(1), 256'(0));
            end else begin
               if (!in_pkt) begin
                  out_start_q.push_back(cyc);
                  cur_src = exp_src_q.pop_front();
                  in_pkt  = 1'b1;
                  beats   = 0;
               end
               beats++;
               e = exp_q.pop_front();
               check("beat", 256'(got), 256'(e));
               if (got.last) begin
                  in_pkt   = 1'b0;
                  last_src = cur_src;
                  pkt_count++;
                  $display("pkt %0d: port %0d, %0d beats, done at cycle %0d", pkt_count, cur_src, beats, cyc);
               end
            end
         end
         if (exp_q.size() == 0) break;
      end
      if (abort_cyc == 0) begin
         check("all_delivered", 256'(exp_q.size()), 256'(0));
         check("hold_stable", 256'(hold_bad), 256'(0));
         check("tready_onehot", 256'(onehot_bad), 256'(0));
         repeat (4) @(negedge clk);
         check("idle_after", 256'(m_if.tvalid), 256'(0));
      end
   endtask

   initial begin
      s_if.tvalid = '0;
      s_if.tlast  = '0;
      s_if.tdata  = '0;
      s_if.tstrb  = '0;
      s_if.tuser  = '0;
      m_if.tready = 1'b0;

      // Equal weights, 4-beat packets, free-flowing output.
      weights = {NP{4'd1}};
      do_reset();
      for (int k = 0; k < 2; k++) for (int p = 0; p < NP; p++) add_pkt(p, 4);
      build_expected();
      rdy_mode = 0;
      bubbles  = 0;
      run(400, 0);
      check("first_latency", 256'(first_out), 256'(2));
      for (int i = 1; i < out_start_q.size(); i++)
         check("pkt_spacing", 256'(out_start_q[i] - out_start_q[i-1]), 256'(5));

      // Port 0 weight 3, everyone contending, random stalls.
      do_reset();
      weights = {4'd1, 4'd1, 4'd1, 4'd1, 4'd3};
      for (int p = 0; p < NP; p++) for (int k = 0; k < 4; k++) add_pkt(p, $urandom_range(1, 4));
      build_expected();
      rdy_mode = 1;
      bubbles  = 1;
      run(2000, 0);

      // Single port with weight 0.
      do_reset();
      weights = '0;
      for (int k = 0; k < 4; k++) add_pkt(3, 2);
      build_expected();
      rdy_mode = 0;
      bubbles  = 0;
      run(400, 0);
      check("w0_last_port", 256'(cur_port), 256'(3));

      // Toggling downstream ready with a 5-cycle hold.
      do_reset();
      weights = 20'($urandom);
      for (int p = 0; p < NP; p++) for (int k = 0; k < 2; k++) add_pkt(p, $urandom_range(3, 6));
      build_expected();
      rdy_mode = 2;
      run(2000, 0);

      // Port 2 stalls mid-packet while port 4 waits.
      do_reset();
      weights = {NP{4'd1}};
      add_pkt(2, 6);
      add_pkt(4, 3);
      build_expected();
      stall_port = 2;
      stall_pos  = 2;
      stall_left = 10;
      rdy_mode   = 0;
      run(400, 0);
      check("stall_consumed", 256'(stall_left), 256'(0));
      stall_port = -1;

      // Asynchronous reset mid-packet, then arbitration restarts from port 0.
      do_reset();
      add_pkt(1, 8);
      add_pkt(3, 8);
      build_expected();
      rdy_mode = 3;
      run(100, 6);
      check("pre_rst_tvalid", 256'(m_if.tvalid), 256'(1));
      check("pre_rst_busy", 256'(busy), 256'(1));
      do_reset();
      add_pkt(3, 3);
      add_pkt(1, 2);
      build_expected();
      check("post_rst_first_port", 256'(exp_src_q[0]), 256'(1));
      rdy_mode = 0;
      run(400, 0);

      // Fully random traffic and weights.
      for (int r = 0; r < 2; r++) begin
         do_reset();
         weights = 20'($urandom);
         for (int p = 0; p < NP; p++) begin
            int n;
            n = $urandom_range(1, 5);
            for (int k = 0; k < n; k++) add_pkt(p, $urandom_range(1, 8));
         end
         build_expected();
         rdy_mode = 1;
         bubbles  = 1;
         run(4000, 0);
         check("final_cur_port", 256'(cur_port), 256'(last_src));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
